col_input_fifo: RTL
===================

# col_input_fifo

Buffered input FIFO for one systolic-array column. It sits directly upstream of the column FIFO controller. It accepts operand words from the loader over a valid/ready stream, stores them in a power-of-two deep buffer, and publishes `o_empty` and a live `o_occupants` count. The controller uses these to decide when a full ROW×COL frame is resident. On the controller's single-cycle read strobe, the block returns the next word one cycle later.

## Interface
- `W_DATA`, 8, operand word width.
- `W_ADDR`, 8, address width; depth DEPTH = 2^W_ADDR.
- `COL`, 1, columns served; used only for frame threshold.
- `ROW`, 9, rows per column; frame size FRAME = COL*ROW, must be ≤ DEPTH (checked at elaboration).
- `i_clk`  in  1  clock, all logic on rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_clear`  in  1  synchronous flush of contents; pointers and count to 0.
- `i_wr_valid`  in  1  upstream word valid.
- `o_wr_ready`  out  1  FIFO can accept a word this cycle.
- `i_wr_data`  in  W_DATA  upstream word.
- `i_rd_en`  in  1  read strobe from column controller.
- `o_rd_data`  out  W_DATA  read word, registered.
- `o_rd_valid`  out  1  `o_rd_data` valid this cycle.
- `o_empty`  out  1  occupants == 0.
- `o_full`  out  1  occupants == DEPTH.
- `o_occupants`  out  W_ADDR+1  words currently stored, 0..DEPTH.
- `o_frame_ready`  out  1  occupants ≥ FRAME.
- `o_overflow`  out  1  sticky: `i_wr_valid` seen while full.
- `o_underflow`  out  1  sticky: `i_rd_en` seen while empty.

## Operation
- Write accept: `wr_fire = i_wr_valid & o_wr_ready`. `o_wr_ready = ~o_full`, driven from registered state only, with no combinational path from `i_rd_en`.
- Read accept: `rd_fire = i_rd_en & ~o_empty`. A read while empty is ignored and sets `o_underflow`.
- Pointers: `wr_ptr` and `rd_ptr` are W_ADDR bits and wrap naturally from DEPTH-1 to 0. Full and empty are decided by `o_occupants`, never by pointer compare.
- Count update per cycle:
  - wr_fire only: +1.
  - rd_fire only: −1.
  - both, or neither: unchanged.
- Simultaneous write and read:
  - At occupants 0: the write fires, the read is ignored and counts as underflow. Count goes 0→1; no write-through bypass.
  - At occupants DEPTH: `o_wr_ready` is 0, so only the read fires. Count goes DEPTH→DEPTH-1.
- `o_overflow` and `o_underflow` are sticky. They clear only on `i_rst` or `i_clear`.
- `i_clear`: pointers, count, `o_rd_valid` and sticky flags go to 0 on the next edge. Any wr_fire or rd_fire in the same cycle is discarded. `i_clear` has priority over all traffic.
- `i_rst` mid-operation has the same effect as `i_clear`. Storage contents are don't-care after either.
- `o_empty`, `o_full` and `o_frame_ready` are combinational decodes of the `o_occupants` register.

## Timing
- Reset values:
  - `o_wr_ready` = 1.
  - `o_rd_data` = 0.
  - `o_rd_valid` = 0.
  - `o_empty` = 1.
  - `o_full` = 0.
  - `o_occupants` = 0.
  - `o_frame_ready` = 0.
  - `o_overflow` = 0.
  - `o_underflow` = 0.
- Write-to-visibility: a word accepted at edge N is counted in `o_occupants` after edge N and readable from cycle N+1.
- Read latency: rd_fire in cycle N gives `o_rd_data`/`o_rd_valid` = 1 in cycle N+1 only. `o_rd_data` holds its value until the next rd_fire.
- Back-to-back reads are supported, one per cycle. The downstream controller issues one every two cycles.
- Throughput: one write and one read per cycle sustained, provided the FIFO is neither empty nor full.

## Structure
- Shared package/header `sa_pkg`: default W_DATA, W_ADDR, ROW, COL, and the FRAME derivation, shared with the column controller so the frame threshold matches.
- One sub-module, `col_fifo_ram`: simple dual-port RAM, DEPTH×W_DATA, one write port, registered read port with one-cycle latency. It is inferable as block RAM.
- Top level holds the pointers, count, flags and handshake.

## Test plan
- Reset, then write 9 words 0x01..0x09 (ROW=9, COL=1):
  - `o_occupants` steps 1..9.
  - `o_frame_ready` rises the cycle after the 9th accept.
  - `o_empty` falls after the first accept.
- Nine `i_rd_en` pulses, one every 2 cycles: `o_rd_data` returns 0x01..0x09 in order, each with a one-cycle `o_rd_valid` the cycle after its strobe. Count ends at 0 and `o_empty` = 1.
- Fill to 256 words:
  - `o_full` = 1 and `o_wr_ready` = 0.
  - Holding `i_wr_valid` sets `o_overflow` with count unchanged at 256.
  - One read then drops the count to 255 and `o_wr_ready` returns to 1.
- Wrap-around: 300 writes interleaved with reads, occupancy kept between 1 and 20. Data order is preserved across the pointer wrap at 255→0.
- Simultaneous `i_wr_valid` and `i_rd_en` at count 5: count stays 5 and the read returns the oldest word. The same stimulus at count 0 gives count 1, no `o_rd_valid`, and `o_underflow` = 1.
- Assert `i_clear` (then separately `i_rst`) at count 7 during a write and a read: next cycle count = 0, `o_empty` = 1, sticky flags = 0, `o_rd_valid` = 0.

Source files
------------

// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Systolic-array parameters shared by the column input FIFO and the column
// FIFO controller. Both blocks derive the frame threshold from the same
// function, so they always agree on how many words make up one frame.
//   SA_W_DATA : operand word width
//   SA_W_ADDR : FIFO address width (depth = 2**SA_W_ADDR)
//   SA_ROW    : rows per column
//   SA_COL    : columns served by one FIFO
// ---------------------------------------------------------------------------
package sa_pkg;

    localparam int SA_W_DATA = 8;
    localparam int SA_W_ADDR = 8;
    localparam int SA_ROW    = 9;
    localparam int SA_COL    = 1;

    // Number of words that make up one resident ROW x COL frame.
    function automatic int sa_frame(input int col, input int row);
        return col * row;
    endfunction

    localparam int SA_FRAME = sa_frame(SA_COL, SA_ROW);

endpackage

// File: rtl/col_fifo_ram.sv
// ---------------------------------------------------------------------------
// col_fifo_ram
// Simple dual-port RAM, (2**W_ADDR) x W_DATA, one write port and one
// registered read port with one cycle of latency. Written so that synthesis
// maps it onto block RAM; the read output register has a synchronous reset,
// which block RAM output registers support.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset of the read output register
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_re    : read enable; o_rdata updates only when asserted
//   i_raddr : read address
//   o_rdata : registered read data, held between reads
// ---------------------------------------------------------------------------
module col_fifo_ram
    import sa_pkg::*;
#(
    parameter int W_DATA = SA_W_DATA,
    parameter int W_ADDR = SA_W_ADDR
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [W_ADDR-1:0] i_waddr,
    input  logic [W_DATA-1:0] i_wdata,
    input  logic              i_re,
    input  logic [W_ADDR-1:0] i_raddr,
    output logic [W_DATA-1:0] o_rdata
);

    localparam int DEPTH = 1 << W_ADDR;

    logic [W_DATA-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // ---- read stage p1: registered read port ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/col_input_fifo.sv
// ---------------------------------------------------------------------------
// col_input_fifo
// Buffered input FIFO for one systolic-array column. Accepts operand words
// over a valid/ready stream, stores them in a power-of-two deep RAM and
// reports a live occupancy count so the column controller can tell when a
// full ROW x COL frame is resident. A single-cycle read strobe returns the
// oldest word one cycle later.
// Ports:
//   i_clk         : clock, rising edge
//   i_rst         : synchronous active-high reset
//   i_clear       : synchronous flush (pointers, count, flags to 0)
//   i_wr_valid    : upstream word valid
//   o_wr_ready    : FIFO can accept a word this cycle (not full)
//   i_wr_data     : upstream word
//   i_rd_en       : read strobe from the column controller
//   o_rd_data     : registered read word, held until the next accepted read
//   o_rd_valid    : o_rd_data carries a freshly read word this cycle
//   o_empty       : occupancy == 0
//   o_full        : occupancy == DEPTH
//   o_occupants   : words currently stored, 0..DEPTH
//   o_frame_ready : occupancy >= FRAME
//   o_overflow    : sticky, write attempted while full
//   o_underflow   : sticky, read attempted while empty
// ---------------------------------------------------------------------------
module col_input_fifo
    import sa_pkg::*;
#(
    parameter int W_DATA = SA_W_DATA,
    parameter int W_ADDR = SA_W_ADDR,
    parameter int COL    = SA_COL,
    parameter int ROW    = SA_ROW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [W_DATA-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [W_DATA-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_empty,
    output logic              o_full,
    output logic [W_ADDR:0]   o_occupants,
    output logic              o_frame_ready,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int DEPTH = 1 << W_ADDR;
    localparam int FRAME = sa_frame(COL, ROW);

    localparam logic [W_ADDR:0]   DEPTH_CNT = (W_ADDR + 1)'(DEPTH);
    localparam logic [W_ADDR:0]   FRAME_CNT = (W_ADDR + 1)'(FRAME);
    localparam logic [W_ADDR:0]   CNT_ONE   = (W_ADDR + 1)'(1);
    localparam logic [W_ADDR-1:0] PTR_ONE   = W_ADDR'(1);

    // A frame that cannot fit in the buffer would never raise o_frame_ready.
    generate
        if (FRAME > DEPTH || FRAME < 1) begin : g_frame_chk
            $error("col_input_fifo: FRAME=COL*ROW must be in 1..2**W_ADDR");
        end
    endgenerate

    logic [W_ADDR-1:0] wr_ptr;
    logic [W_ADDR-1:0] rd_ptr;
    logic [W_ADDR:0]   occ_cnt;
    logic              vld_p1;
    logic              ovf_flag;
    logic              unf_flag;

    logic              full;
    logic              empty;
    logic              wr_fire;
    logic              rd_fire;
    logic              flush;

    // Full/empty come from the count register only, so o_wr_ready has no
    // combinational path from i_rd_en.
    assign full    = (occ_cnt == DEPTH_CNT);
    assign empty   = (occ_cnt == '0);
    assign wr_fire = i_wr_valid & ~full;
    assign rd_fire = i_rd_en & ~empty;
    assign flush   = i_rst | i_clear;

    // ---- stage p0: pointers, count, sticky flags ----
    always_ff @(posedge i_clk) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ_cnt  <= '0;
            vld_p1   <= 1'b0;
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A write and a read in the same cycle leave the count unchanged.
            case ({wr_fire, rd_fire})
                2'b10:   occ_cnt <= occ_cnt + CNT_ONE;
                2'b01:   occ_cnt <= occ_cnt - CNT_ONE;
                default: occ_cnt <= occ_cnt;
            endcase
            vld_p1 <= rd_fire;
            if (i_wr_valid && full) begin
                ovf_flag <= 1'b1;
            end
            if (i_rd_en && empty) begin
                unf_flag <= 1'b1;
            end
        end
    end

    // Storage is gated by flush so a discarded transfer never touches the
    // RAM or the held read word. A read never targets the slot being written:
    // rd_ptr == wr_ptr only when empty (no read) or full (no write).
    col_fifo_ram #(
        .W_DATA (W_DATA),
        .W_ADDR (W_ADDR)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (wr_fire & ~flush),
        .i_waddr (wr_ptr),
        .i_wdata (i_wr_data),
        .i_re    (rd_fire & ~flush),
        .i_raddr (rd_ptr),
        .o_rdata (o_rd_data)
    );

    // ---- stage p1: outputs ----
    assign o_wr_ready    = ~full;
    assign o_rd_valid    = vld_p1;
    assign o_empty       = empty;
    assign o_full        = full;
    assign o_occupants   = occ_cnt;
    assign o_frame_ready = (occ_cnt >= FRAME_CNT);
    assign o_overflow    = ovf_flag;
    assign o_underflow   = unf_flag;

endmodule
